// File: rtl/butterfly_dif.sv
// butterfly_dif: radix-2 decimation-in-frequency butterfly, 6-stage pipeline.
//   YP = XP + XQ
//   YQ = (XP - XQ) * TF   (complex; TF is fixed point, 1.0 = 2^FRACWIDTH)
// Optional build macro BUTTERFLY_DIF_ROUND_EN: round half up before the
// fractional shift. Without it the shift truncates (floor). Latency is the
// same in both builds.
// Handshake: VALID_IN qualifies the input set sampled on an EN-high rising
// edge. VALID_OUT marks the matching result 6 EN-high edges later. There is
// no back-pressure. EN=0 freezes the whole pipeline, including the outputs.
module butterfly_dif #(
    parameter int INWIDTH   = 16,
    parameter int FRACWIDTH = 13
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      EN,
    input  logic                      VALID_IN,
    input  logic signed [INWIDTH-1:0] XP_R,
    input  logic signed [INWIDTH-1:0] XP_I,
    input  logic signed [INWIDTH-1:0] XQ_R,
    input  logic signed [INWIDTH-1:0] XQ_I,
    input  logic signed [INWIDTH-1:0] TF_R,
    input  logic signed [INWIDTH-1:0] TF_I,
    output logic                      VALID_OUT,
    output logic signed [INWIDTH:0]   YP_R,
    output logic signed [INWIDTH:0]   YP_I,
    output logic signed [INWIDTH:0]   YQ_R,
    output logic signed [INWIDTH:0]   YQ_I
);

    localparam int W1 = INWIDTH + 1;       // sum / difference / output width
    localparam int PW = 2 * INWIDTH + 1;   // partial product width
    localparam int SW = 2 * INWIDTH + 2;   // accumulated product width

    // Output clamp limits, expressed at the wide (pre-saturation) width.
    localparam logic signed [SW-1:0] SAT_MAX = $signed({{(SW-INWIDTH){1'b0}}, {INWIDTH{1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = $signed({{(SW-INWIDTH){1'b1}}, {INWIDTH{1'b0}}});
`ifdef BUTTERFLY_DIF_ROUND_EN
    // Half an LSB of the scaled result.
    localparam logic signed [SW-1:0] RND = $signed({{(SW-1){1'b0}}, 1'b1} << (FRACWIDTH - 1));
`endif

    // Sign-extension helpers for the multiply and accumulate widths.
    function automatic logic signed [W1-1:0] ext_w1(input logic signed [INWIDTH-1:0] a);
        return $signed({a[INWIDTH-1], a});
    endfunction

    function automatic logic signed [PW-1:0] ext_pw_d(input logic signed [W1-1:0] a);
        return $signed({{(PW-W1){a[W1-1]}}, a});
    endfunction

    function automatic logic signed [PW-1:0] ext_pw_t(input logic signed [INWIDTH-1:0] a);
        return $signed({{(PW-INWIDTH){a[INWIDTH-1]}}, a});
    endfunction

    function automatic logic signed [SW-1:0] ext_sw(input logic signed [PW-1:0] a);
        return $signed({a[PW-1], a});
    endfunction

    function automatic logic signed [W1-1:0] sat(input logic signed [SW-1:0] a);
        if (a > SAT_MAX) begin
            return SAT_MAX[W1-1:0];
        end else if (a < SAT_MIN) begin
            return SAT_MIN[W1-1:0];
        end else begin
            return a[W1-1:0];
        end
    endfunction

    // S1: registered inputs
    logic signed [INWIDTH-1:0] xp_r_q, xp_i_q, xq_r_q, xq_i_q, tf_r1_q, tf_i1_q;
    logic signed [INWIDTH-1:0] xp_r_d, xp_i_d, xq_r_d, xq_i_d, tf_r1_d, tf_i1_d;
    // S2: sum, difference, twiddle delayed to meet the difference
    logic signed [W1-1:0]      sum_r2_q, sum_i2_q, dif_r_q, dif_i_q;
    logic signed [W1-1:0]      sum_r2_d, sum_i2_d, dif_r_d, dif_i_d;
    logic signed [INWIDTH-1:0] tf_r2_q, tf_i2_q, tf_r2_d, tf_i2_d;
    // S3: partial products
    logic signed [W1-1:0]      sum_r3_q, sum_i3_q, sum_r3_d, sum_i3_d;
    logic signed [PW-1:0]      p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [PW-1:0]      p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    // S4: complex product
    logic signed [W1-1:0]      sum_r4_q, sum_i4_q, sum_r4_d, sum_i4_d;
    logic signed [SW-1:0]      pr_q, pi_q, pr_d, pi_d;
    // S5: scaled product
    logic signed [W1-1:0]      sum_r5_q, sum_i5_q, sum_r5_d, sum_i5_d;
    logic signed [SW-1:0]      sc_r_q, sc_i_q, sc_r_d, sc_i_d;
    // S6: outputs
    logic signed [W1-1:0]      yp_r_q, yp_i_q, yq_r_q, yq_i_q;
    logic signed [W1-1:0]      yp_r_d, yp_i_d, yq_r_d, yq_i_d;
    // Valid shift register, bit 0 = S1, bit 5 = S6
    logic [5:0]                valid_q, valid_d;

    // Next-value computation for every pipeline stage.
    always_comb begin
        // S1
        xp_r_d  = XP_R;
        xp_i_d  = XP_I;
        xq_r_d  = XQ_R;
        xq_i_d  = XQ_I;
        tf_r1_d = TF_R;
        tf_i1_d = TF_I;
        // S2: one extra bit makes the sum and difference exact
        sum_r2_d = ext_w1(xp_r_q) + ext_w1(xq_r_q);
        sum_i2_d = ext_w1(xp_i_q) + ext_w1(xq_i_q);
        dif_r_d  = ext_w1(xp_r_q) - ext_w1(xq_r_q);
        dif_i_d  = ext_w1(xp_i_q) - ext_w1(xq_i_q);
        tf_r2_d  = tf_r1_q;
        tf_i2_d  = tf_i1_q;
        // S3
        sum_r3_d = sum_r2_q;
        sum_i3_d = sum_i2_q;
        p_rr_d   = ext_pw_d(dif_r_q) * ext_pw_t(tf_r2_q);
        p_ii_d   = ext_pw_d(dif_i_q) * ext_pw_t(tf_i2_q);
        p_ri_d   = ext_pw_d(dif_r_q) * ext_pw_t(tf_i2_q);
        p_ir_d   = ext_pw_d(dif_i_q) * ext_pw_t(tf_r2_q);
        // S4
        sum_r4_d = sum_r3_q;
        sum_i4_d = sum_i3_q;
        pr_d     = ext_sw(p_rr_q) - ext_sw(p_ii_q);
        pi_d     = ext_sw(p_ri_q) + ext_sw(p_ir_q);
        // S5: drop the twiddle fraction bits
        sum_r5_d = sum_r4_q;
        sum_i5_d = sum_i4_q;
`ifdef BUTTERFLY_DIF_ROUND_EN
        sc_r_d   = (pr_q + RND) >>> FRACWIDTH;
        sc_i_d   = (pi_q + RND) >>> FRACWIDTH;
`else
        sc_r_d   = pr_q >>> FRACWIDTH;
        sc_i_d   = pi_q >>> FRACWIDTH;
`endif
        // S6: the sum path needs no clamp, the product path does
        yp_r_d   = sum_r5_q;
        yp_i_d   = sum_i5_q;
        yq_r_d   = sat(sc_r_q);
        yq_i_d   = sat(sc_i_q);
        // Valid travels alongside the data
        valid_d  = {valid_q[4:0], VALID_IN};
    end

    // Pipeline registers: async clear, advance only when EN is high.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            xp_r_q   <= '0;
            xp_i_q   <= '0;
            xq_r_q   <= '0;
            xq_i_q   <= '0;
            tf_r1_q  <= '0;
            tf_i1_q  <= '0;
            sum_r2_q <= '0;
            sum_i2_q <= '0;
            dif_r_q  <= '0;
            dif_i_q  <= '0;
            tf_r2_q  <= '0;
            tf_i2_q  <= '0;
            sum_r3_q <= '0;
            sum_i3_q <= '0;
            p_rr_q   <= '0;
            p_ii_q   <= '0;
            p_ri_q   <= '0;
            p_ir_q   <= '0;
            sum_r4_q <= '0;
            sum_i4_q <= '0;
            pr_q     <= '0;
            pi_q     <= '0;
            sum_r5_q <= '0;
            sum_i5_q <= '0;
            sc_r_q   <= '0;
            sc_i_q   <= '0;
            yp_r_q   <= '0;
            yp_i_q   <= '0;
            yq_r_q   <= '0;
            yq_i_q   <= '0;
            valid_q  <= '0;
        end else if (EN) begin
            xp_r_q   <= xp_r_d;
            xp_i_q   <= xp_i_d;
            xq_r_q   <= xq_r_d;
            xq_i_q   <= xq_i_d;
            tf_r1_q  <= tf_r1_d;
            tf_i1_q  <= tf_i1_d;
            sum_r2_q <= sum_r2_d;
            sum_i2_q <= sum_i2_d;
            dif_r_q  <= dif_r_d;
            dif_i_q  <= dif_i_d;
            tf_r2_q  <= tf_r2_d;
            tf_i2_q  <= tf_i2_d;
            sum_r3_q <= sum_r3_d;
            sum_i3_q <= sum_i3_d;
            p_rr_q   <= p_rr_d;
            p_ii_q   <= p_ii_d;
            p_ri_q   <= p_ri_d;
            p_ir_q   <= p_ir_d;
            sum_r4_q <= sum_r4_d;
            sum_i4_q <= sum_i4_d;
            pr_q     <= pr_d;
            pi_q     <= pi_d;
            sum_r5_q <= sum_r5_d;
            sum_i5_q <= sum_i5_d;
            sc_r_q   <= sc_r_d;
            sc_i_q   <= sc_i_d;
            yp_r_q   <= yp_r_d;
            yp_i_q   <= yp_i_d;
            yq_r_q   <= yq_r_d;
            yq_i_q   <= yq_i_d;
            valid_q  <= valid_d;
        end
    end

    assign VALID_OUT = valid_q[5];
    assign YP_R      = yp_r_q;
    assign YP_I      = yp_i_q;
    assign YQ_R      = yq_r_q;
    assign YQ_I      = yq_i_q;

endmodule

// File: tb/tb_butterfly_dif.sv
// Directed testbench for butterfly_dif (INWIDTH=16, FRACWIDTH=13).
// Expected values are hand-computed; the rounding cases select their
// expectation from BUTTERFLY_DIF_ROUND_EN.
module tb_butterfly_dif;

    // ---------------- clock / reset / signals ----------------
    logic               CLK = 1'b0;
    logic               RESET_N;
    logic               EN;
    logic               VALID_IN;
    logic signed [15:0] XP_R, XP_I, XQ_R, XQ_I, TF_R, TF_I;
    logic               VALID_OUT;
    logic signed [16:0] YP_R, YP_I, YQ_R, YQ_I;

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BUTTERFLY_DIF_ROUND_EN
    localparam int EXP_POS3 = 2;
    localparam int EXP_NEG3 = -1;
`else
    localparam int EXP_POS3 = 1;
    localparam int EXP_NEG3 = -2;
`endif

    string out_nm[4] = '{"yp_r", "yp_i", "yq_r", "yq_i"};

    butterfly_dif #(.INWIDTH(16), .FRACWIDTH(13)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .EN       (EN),
        .VALID_IN (VALID_IN),
        .XP_R     (XP_R),
        .XP_I     (XP_I),
        .XQ_R     (XQ_R),
        .XQ_I     (XQ_I),
        .TF_R     (TF_R),
        .TF_I     (TF_I),
        .VALID_OUT(VALID_OUT),
        .YP_R     (YP_R),
        .YP_I     (YP_I),
        .YQ_R     (YQ_R),
        .YQ_I     (YQ_I)
    );

    // ---------------- driver tasks ----------------
    task automatic set_in(input int xpr, input int xpi, input int xqr, input int xqi,
                          input int tfr, input int tfi, input logic v);
        XP_R     = 16'(xpr);
        XP_I     = 16'(xpi);
        XQ_R     = 16'(xqr);
        XQ_I     = 16'(xqi);
        TF_R     = 16'(tfr);
        TF_I     = 16'(tfi);
        VALID_IN = v;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (n) @(negedge CLK);
    endtask

    // Present one valid set for a single EN-high edge, then go idle.
    task automatic send_one(input int xpr, input int xpi, input int xqr, input int xqi,
                            input int tfr, input int tfi);
        set_in(xpr, xpi, xqr, xqi, tfr, tfi, 1'b1);
        @(negedge CLK);
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    // Waits (bounded) for VALID_OUT; 'start' edges have already elapsed.
    task automatic wait_valid(input int start, output int cyc);
        cyc = -1;
        for (int i = start + 1; i <= start + 20; i++) begin
            @(negedge CLK);
            if (VALID_OUT === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    function automatic int out_val(input int k);
        case (k)
            0:       return int'(YP_R);
            1:       return int'(YP_I);
            2:       return int'(YQ_R);
            default: return int'(YQ_I);
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        EN      = 1'b1;
        idle(2);
        n_cmp++;
        if (VALID_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL reset valid_out: got %b want 0", VALID_OUT);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== 0) begin
                n_err++;
                $display("FAIL reset %s: got %0d want 0", out_nm[k], out_val(k));
            end
        end
        RESET_N = 1'b1;
        idle(8);
        n_cmp++;
        if (VALID_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL reset idle valid_out: got %b want 0", VALID_OUT);
        end
    endtask

    task automatic test_basic();
        int cyc;
        int exp_v[4];
        idle(8);
        send_one(1000, 0, 200, 0, 8192, 0);
        wait_valid(1, cyc);
        n_cmp++;
        if (cyc !== 6) begin
            n_err++;
            $display("FAIL basic latency: got %0d want 6", cyc);
        end
        exp_v = '{1200, 0, 800, 0};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== exp_v[k]) begin
                n_err++;
                $display("FAIL basic %s: got %0d want %0d", out_nm[k], out_val(k), exp_v[k]);
            end
        end
    endtask

    task automatic test_rotate();
        int cyc;
        int exp_v[4];
        idle(8);
        send_one(1000, 0, 200, 0, 0, -8192);
        wait_valid(1, cyc);
        n_cmp++;
        if (cyc !== 6) begin
            n_err++;
            $display("FAIL rotate latency: got %0d want 6", cyc);
        end
        exp_v = '{1200, 0, 0, -800};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== exp_v[k]) begin
                n_err++;
                $display("FAIL rotate %s: got %0d want %0d", out_nm[k], out_val(k), exp_v[k]);
            end
        end
    endtask

    task automatic test_saturate();
        int cyc;
        int exp_v[4];
        // Positive overflow of the product path.
        idle(8);
        send_one(32767, 0, -32768, 0, 32767, 0);
        wait_valid(1, cyc);
        n_cmp++;
        if (cyc !== 6) begin
            n_err++;
            $display("FAIL sat_pos latency: got %0d want 6", cyc);
        end
        exp_v = '{-1, 0, 65535, 0};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== exp_v[k]) begin
                n_err++;
                $display("FAIL sat_pos %s: got %0d want %0d", out_nm[k], out_val(k), exp_v[k]);
            end
        end
        // Negative overflow of the product path.
        idle(8);
        send_one(-32768, 0, 32767, 0, 32767, 0);
        wait_valid(1, cyc);
        exp_v = '{-1, 0, -65536, 0};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== exp_v[k]) begin
                n_err++;
                $display("FAIL sat_neg %s: got %0d want %0d", out_nm[k], out_val(k), exp_v[k]);
            end
        end
    endtask

    // Four sets on consecutive edges, including the rounding boundary cases.
    task automatic test_back_to_back();
        int cyc;
        int vec[4][6];
        int exp_v[4][4];
        vec[0] = '{3, 0, 0, 0, 4096, 0};
        vec[1] = '{-3, 0, 0, 0, 4096, 0};
        vec[2] = '{1000, 0, 200, 0, 8192, 0};
        vec[3] = '{1000, 0, 200, 0, 0, -8192};
        exp_v[0] = '{3, 0, EXP_POS3, 0};
        exp_v[1] = '{-3, 0, EXP_NEG3, 0};
        exp_v[2] = '{1200, 0, 800, 0};
        exp_v[3] = '{1200, 0, 0, -800};
        idle(8);
        for (int s = 0; s < 4; s++) begin
            set_in(vec[s][0], vec[s][1], vec[s][2], vec[s][3], vec[s][4], vec[s][5], 1'b1);
            @(negedge CLK);
        end
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        wait_valid(4, cyc);
        n_cmp++;
        if (cyc !== 6) begin
            n_err++;
            $display("FAIL b2b latency: got %0d want 6", cyc);
        end
        for (int s = 0; s < 4; s++) begin
            if (s > 0) @(negedge CLK);
            n_cmp++;
            if (VALID_OUT !== 1'b1) begin
                n_err++;
                $display("FAIL b2b set%0d valid_out: got %b want 1", s, VALID_OUT);
            end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (out_val(k) !== exp_v[s][k]) begin
                    n_err++;
                    $display("FAIL b2b set%0d %s: got %0d want %0d", s, out_nm[k], out_val(k), exp_v[s][k]);
                end
            end
        end
        @(negedge CLK);
        n_cmp++;
        if (VALID_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL b2b trailing valid_out: got %b want 0", VALID_OUT);
        end
    endtask

    // Single set, EN low for 3 edges mid-pipe, then a freeze with valid output.
    task automatic test_stall();
        int cyc;
        int exp_v[4];
        idle(8);
        send_one(500, -300, 100, 100, 4096, 4096);   // edge 1
        repeat (2) @(negedge CLK);                     // edges 2, 3
        EN = 1'b0;
        set_in(7777, -7777, 1234, 4321, 8192, 8192, 1'b1);
        for (int j = 0; j < 3; j++) begin              // edges 4..6 stalled
            @(negedge CLK);
            n_cmp++;
            if (VALID_OUT !== 1'b0 || YP_R !== 17'sd0) begin
                n_err++;
                $display("FAIL stall hold%0d: got valid=%b yp_r=%0d want valid=0 yp_r=0", j, VALID_OUT, YP_R);
            end
        end
        EN = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        wait_valid(6, cyc);
        n_cmp++;
        if (cyc !== 9) begin
            n_err++;
            $display("FAIL stall latency: got %0d want 9", cyc);
        end
        exp_v = '{600, -200, 400, 0};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== exp_v[k]) begin
                n_err++;
                $display("FAIL stall %s: got %0d want %0d", out_nm[k], out_val(k), exp_v[k]);
            end
        end
        EN = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge CLK);
            n_cmp++;
            if (VALID_OUT !== 1'b1 || YP_R !== 17'sd600 || YQ_R !== 17'sd400) begin
                n_err++;
                $display("FAIL stall freeze%0d: got valid=%b yp_r=%0d yq_r=%0d want 1/600/400", j, VALID_OUT, YP_R, YQ_R);
            end
        end
        EN = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (VALID_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL stall after valid_out: got %b want 0", VALID_OUT);
        end
    endtask

    // Reset in the middle of a burst flushes everything in flight.
    task automatic test_reset_midflight();
        int cyc;
        int seen;
        int exp_v[4];
        idle(8);
        send_one(1000, 0, 200, 0, 8192, 0);            // edge 1: preload set
        repeat (3) @(negedge CLK);                     // edges 2..4
        set_in(100, 50, 20, 10, 8192, 0, 1'b1);        // set 1
        @(negedge CLK);                                // edge 5
        set_in(-200, 70, 30, -40, 0, 8192, 1'b1);      // set 2
        @(negedge CLK);                                // edge 6
        n_cmp++;
        if (VALID_OUT !== 1'b1 || YP_R !== 17'sd1200) begin
            n_err++;
            $display("FAIL rst_mid pre: got valid=%b yp_r=%0d want 1/1200", VALID_OUT, YP_R);
        end
        RESET_N = 1'b0;
        set_in(300, 300, 100, 100, 8192, 0, 1'b1);     // set 3
        #1;
        n_cmp++;
        if (VALID_OUT !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid valid_out: got %b want 0", VALID_OUT);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== 0) begin
                n_err++;
                $display("FAIL rst_mid %s: got %0d want 0", out_nm[k], out_val(k));
            end
        end
        @(negedge CLK);
        set_in(-300, 10, 50, 60, 4096, 0, 1'b1);       // set 4
        @(negedge CLK);
        RESET_N = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        seen = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge CLK);
            if (VALID_OUT === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rst_mid stale valid: got %0d cycles want 0", seen);
        end
        send_one(-500, 250, -100, 50, 8192, 0);
        wait_valid(1, cyc);
        n_cmp++;
        if (cyc !== 6) begin
            n_err++;
            $display("FAIL rst_mid post latency: got %0d want 6", cyc);
        end
        exp_v = '{-600, 300, -400, 200};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_val(k) !== exp_v[k]) begin
                n_err++;
                $display("FAIL rst_mid post %s: got %0d want %0d", out_nm[k], out_val(k), exp_v[k]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        RESET_N = 1'b0;
        EN      = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        test_reset();
        test_basic();
        test_rotate();
        test_saturate();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/butterfly_dif.md
BUTTERFLY_DIF -- requirements
Module: butterfly_dif

Interface
REQ-001 SHALL have parameter INWIDTH, default 16, total bitwidth of input samples and twiddle factors.
REQ-002 SHALL have parameter FRACWIDTH, default 13, twiddle fraction bits (1.0 = 2^FRACWIDTH).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port EN  input  1  pipeline advance enable; low = full-pipeline hold.
REQ-006 SHALL have port VALID_IN  input  1  input sample set is valid this cycle.
REQ-007 SHALL have ports XP_R, XP_I, XQ_R, XQ_I  input  INWIDTH signed  inputs p and q, real and imag.
REQ-008 SHALL have ports TF_R, TF_I  input  INWIDTH signed  twiddle factor, real and imag.
REQ-009 SHALL have port VALID_OUT  output  1  output set is valid.
REQ-010 SHALL have ports YP_R, YP_I, YQ_R, YQ_I  output  INWIDTH+1 signed  outputs p and q.

Function
REQ-011 SHALL compute the decimation-in-frequency butterfly, the inverse-order counterpart of the team's DIT butterfly: YP = XP + XQ; YQ = (XP - XQ) * TF (complex).
REQ-012 SHALL run a 6-stage pipeline, each stage advancing only when EN=1:
  - S1: register inputs and VALID_IN.
  - S2: sum and difference, each INWIDTH+1 bits, no overflow possible.
  - S3: four partial products, difference (INWIDTH+1) x TF (INWIDTH).
  - S4: pr = dr*tr - di*ti, pi = dr*ti + di*tr, 2*INWIDTH+2 bits.
  - S5: scale pr and pi by arithmetic shift right of FRACWIDTH bits.
  - S6: saturate to INWIDTH+1 signed range; register outputs.
REQ-013 SHALL delay the S2 sum through S3-S6 unchanged so that YP and YQ from the same input set appear in the same cycle.
REQ-014 SHALL present outputs exactly 6 EN-high rising edges after the inputs are sampled, with VALID_OUT=1 in that same cycle.
REQ-015 SHALL propagate VALID_IN through a 6-deep valid shift register gated by EN; data SHALL also advance when the valid bit is 0.
REQ-016 SHALL hold all pipeline registers, outputs and VALID_OUT unchanged while EN=0, regardless of VALID_IN.
REQ-017 SHALL clamp the S6 result to +(2^INWIDTH - 1) or -2^INWIDTH when the scaled result exceeds INWIDTH+1 signed range, and SHALL pass it unchanged otherwise.
REQ-018 SHALL accept a new input set on every EN-high cycle (throughput 1/cycle), with no bubbles between back-to-back sets.

Reset
REQ-019 SHALL, while RESET_N=0, asynchronously clear all pipeline data registers, the valid shift register, VALID_OUT and all Y outputs to 0.
REQ-020 SHALL discard every in-flight sample when reset asserts mid-operation; the first VALID_OUT after reset release SHALL come from an input sampled after release.

Configuration
REQ-021 SHALL, when macro BUTTERFLY_DIF_ROUND_EN is defined, add 2^(FRACWIDTH-1) to pr and pi before the S5 shift (round half up, toward +inf).
REQ-022 SHALL, when BUTTERFLY_DIF_ROUND_EN is undefined, truncate at S5 (floor via arithmetic shift). Latency and all other behaviour SHALL be identical in both builds.

Verification (INWIDTH=16, FRACWIDTH=13)
REQ-023 SHALL cover: XP=(1000,0), XQ=(200,0), TF=(8192,0), VALID_IN=1, EN=1 -> after 6 cycles VALID_OUT=1, YP=(1200,0), YQ=(800,0).
REQ-024 SHALL cover: XP=(1000,0), XQ=(200,0), TF=(0,-8192) -> YP=(1200,0), YQ=(0,-800).
REQ-025 SHALL cover: XP=(3,0), XQ=(0,0), TF=(4096,0) -> YQ_R=1 truncating, 2 with the macro. Also XP=(-3,0) -> YQ_R=-2 truncating, -1 with the macro.
REQ-026 SHALL cover: XP=(32767,0), XQ=(-32768,0), TF=(32767,0) -> YP_R=-1, YQ_R=65535 (saturated), YQ_I=0.
REQ-027 SHALL cover: a single valid set, then EN=0 for 3 cycles mid-pipe -> VALID_OUT rises after 9 cycles total with correct data, and outputs are frozen during the stall.
REQ-028 SHALL cover: 4 back-to-back valid sets, RESET_N pulsed low after the 2nd set -> all outputs and VALID_OUT are 0 immediately, and no VALID_OUT occurs for the pre-reset sets.
